// File: rtl/tracker_pkg.sv
// Shared types and sizing helpers for the zone blob tracker.
package tracker_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2
  } tracker_state_t;

  localparam int unsigned DEF_NUM_ZONES = 5;
  localparam int unsigned DIR_LEFT      = 0;
  localparam int unsigned DIR_CENTRE    = DEF_NUM_ZONES / 2;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned zone_px(input int unsigned h_active, input int unsigned num_zones);
    return h_active / num_zones;
  endfunction

endpackage

// File: rtl/zone_counter_bank.sv
// Bank of saturating per-zone hit counters with indexed increment, sync clear and indexed read.
module zone_counter_bank #(
  parameter int unsigned NUM_ZONES = 5,
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt_c
);

  logic [CNT_W-1:0] cnt [NUM_ZONES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned z = 0; z < NUM_ZONES; z++) cnt[z] <= '0;
    end else if (clr) begin
      for (int unsigned z = 0; z < NUM_ZONES; z++) cnt[z] <= '0;
    end else begin
      for (int unsigned z = 0; z < NUM_ZONES; z++) begin
        if (inc && (inc_idx == IDX_W'(z)) && (cnt[z] != '1)) cnt[z] <= cnt[z] + 1'b1;
      end
    end
  end

  assign rd_cnt_c = cnt[rd_idx];

endmodule

// File: rtl/zone_blob_tracker.sv
// Per-frame colour-blob tracker: counts class hits per vertical strip, reports the strongest strip.
// Optional multi-frame persistence filter enabled by defining ZONE_TRACKER_PERSIST_EN.
module zone_blob_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned NUM_ZONES   = 5,
  parameter int unsigned NUM_CLASSES = 2,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned MIN_PIXELS  = 200,
  parameter int unsigned PERSIST     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic                          vsync,
  input  logic [NUM_CLASSES-1:0]        class_hit,
  input  logic [idx_w(NUM_CLASSES)-1:0] sel_class,
  output logic [idx_w(NUM_ZONES)-1:0]   direction,
  output logic                          detected,
  output logic [CNT_W-1:0]              best_count,
  output logic                          frame_done
);

  localparam int unsigned ZONE_PX = zone_px(H_ACTIVE, NUM_ZONES);
  localparam int unsigned ZI_W    = idx_w(NUM_ZONES);
  localparam int unsigned PX_W    = idx_w(ZONE_PX);
  localparam int unsigned SEL_W   = idx_w(NUM_CLASSES);

  if (NUM_ZONES < 2 || PERSIST < 1) begin : g_bad_params
    $error("zone_blob_tracker: NUM_ZONES must be >= 2 and PERSIST >= 1");
  end

  tracker_state_t   state, state_next;
  logic             vsync_q;
  logic [PX_W-1:0]  px;
  logic [ZI_W-1:0]  zn;
  logic [SEL_W-1:0] sel_q;
  logic [ZI_W-1:0]  scan_idx;
  logic [CNT_W-1:0] max_cnt;
  logic [ZI_W-1:0]  max_idx;
  logic [CNT_W-1:0] rd_cnt_c;
  logic             inc_c, clr_c, frame_edge_c, cand_ok_c;

  assign frame_edge_c = !vsync && vsync_q;
  assign cand_ok_c    = 32'(max_cnt) >= 32'(MIN_PIXELS);

  zone_counter_bank #(
    .NUM_ZONES (NUM_ZONES),
    .CNT_W     (CNT_W),
    .IDX_W     (ZI_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_c),
    .inc      (inc_c),
    .inc_idx  (zn),
    .rd_idx   (scan_idx),
    .rd_cnt_c (rd_cnt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin : p_next
    state_next = state;
    inc_c      = 1'b0;
    clr_c      = 1'b0;
    case (state)
      ACCUM: begin
        inc_c = pix_valid && class_hit[sel_q];
        if (frame_edge_c) state_next = SCAN;
      end
      SCAN:   if (scan_idx == ZI_W'(NUM_ZONES - 1)) state_next = UPDATE;
      UPDATE: begin
        clr_c      = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

`ifdef ZONE_TRACKER_PERSIST_EN
  localparam int unsigned AG_W = idx_w(PERSIST + 1);

  logic [AG_W-1:0] agree_cnt, agree_next_c;
  logic [ZI_W-1:0] cand_zone;
  logic            cand_valid, same_c;

  // Two invalid candidates agree regardless of which strip happened to be largest.
  always_comb begin : p_agree
    same_c       = (cand_ok_c == cand_valid) && (!cand_ok_c || (max_idx == cand_zone));
    agree_next_c = AG_W'(1);
    if (same_c) agree_next_c = (agree_cnt == AG_W'(PERSIST)) ? agree_cnt : agree_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin : p_data
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      px         <= '0;
      zn         <= '0;
      sel_q      <= '0;
      scan_idx   <= '0;
      max_cnt    <= '0;
      max_idx    <= '0;
      direction  <= ZI_W'(DIR_LEFT);
      detected   <= 1'b0;
      best_count <= '0;
      frame_done <= 1'b0;
`ifdef ZONE_TRACKER_PERSIST_EN
      agree_cnt  <= '0;
      cand_zone  <= '0;
      cand_valid <= 1'b0;
`endif
    end else begin
      vsync_q    <= vsync;
      frame_done <= (state == UPDATE);

      // Column-to-strip mapping; remainder pixels stay in the last strip.
      if (!pix_valid) begin
        px <= '0;
        zn <= '0;
      end else if (px == PX_W'(ZONE_PX - 1)) begin
        px <= '0;
        if (zn != ZI_W'(NUM_ZONES - 1)) zn <= zn + 1'b1;
      end else begin
        px <= px + 1'b1;
      end

      if (state == ACCUM && frame_edge_c) begin
        sel_q    <= sel_class;
        scan_idx <= '0;
        max_cnt  <= '0;
        max_idx  <= '0;
      end

      // Strict compare keeps the lowest index on ties.
      if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (rd_cnt_c > max_cnt) begin
          max_cnt <= rd_cnt_c;
          max_idx <= scan_idx;
        end
      end

      if (state == UPDATE) begin
        best_count <= max_cnt;
`ifdef ZONE_TRACKER_PERSIST_EN
        agree_cnt  <= agree_next_c;
        cand_zone  <= max_idx;
        cand_valid <= cand_ok_c;
        if (agree_next_c == AG_W'(PERSIST)) begin
          detected <= cand_ok_c;
          if (cand_ok_c) direction <= max_idx;
        end
`else
        detected <= cand_ok_c;
        if (cand_ok_c) direction <= max_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_zone_blob_tracker.sv
// Self-checking bench for zone_blob_tracker: randomized frames against a per-frame reference model.
module tb_zone_blob_tracker;

  localparam int H       = 640;
  localparam int NZ      = 5;
  localparam int ZPX     = H / NZ;
  localparam int PERSIST = 3;
  localparam int LAT     = NZ + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pv [2];
  logic       vs [2];
  logic [1:0] ch [2];
  logic [0:0] sc [2];
  logic [2:0] dir [2];
  logic       det [2];
  logic       fd [2];
  logic [16:0] bc0;
  logic [3:0]  bc1;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state per unit
  int m_dir [2], m_det [2], m_best [2], m_sel [2], m_cz [2], m_cv [2], m_ag [2];

  always #20 clk = ~clk;

  zone_blob_tracker #(.H_ACTIVE(H), .NUM_ZONES(NZ), .NUM_CLASSES(2), .CNT_W(17),
                      .MIN_PIXELS(200), .PERSIST(PERSIST)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv[0]), .vsync(vs[0]), .class_hit(ch[0]),
    .sel_class(sc[0]), .direction(dir[0]), .detected(det[0]), .best_count(bc0),
    .frame_done(fd[0]));

  zone_blob_tracker #(.H_ACTIVE(H), .NUM_ZONES(NZ), .NUM_CLASSES(2), .CNT_W(4),
                      .MIN_PIXELS(10), .PERSIST(PERSIST)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv[1]), .vsync(vs[1]), .class_hit(ch[1]),
    .sel_class(sc[1]), .direction(dir[1]), .detected(det[1]), .best_count(bc1),
    .frame_done(fd[1]));

  function automatic int cw_of(input int u);
    return (u == 0) ? 17 : 4;
  endfunction

  function automatic int min_of(input int u);
    return (u == 0) ? 200 : 10;
  endfunction

  function automatic int best_of(input int u);
    return (u == 0) ? int'(bc0) : int'(bc1);
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_dir[u] = 0; m_det[u] = 0; m_best[u] = 0; m_sel[u] = 0;
      m_cz[u] = 0; m_cv[u] = 0; m_ag[u] = 0;
    end
  endfunction

  // One frame's worth of reporting, from per-strip hit totals on the tracked class.
  function automatic void model_frame(input int u, input int q[NZ], input int nsel);
    int sat, c, best, idx, valid;
    sat = (1 << cw_of(u)) - 1;
    best = 0; idx = 0;
    for (int z = 0; z < NZ; z++) begin
      c = (q[z] > sat) ? sat : q[z];
      if (c > best) begin best = c; idx = z; end
    end
    valid = (best >= min_of(u)) ? 1 : 0;
`ifdef ZONE_TRACKER_PERSIST_EN
    if (valid == m_cv[u] && (valid == 0 || idx == m_cz[u]))
      m_ag[u] = (m_ag[u] >= PERSIST) ? PERSIST : m_ag[u] + 1;
    else
      m_ag[u] = 1;
    m_cz[u] = idx; m_cv[u] = valid;
    if (m_ag[u] == PERSIST) begin
      m_det[u] = valid;
      if (valid != 0) m_dir[u] = idx;
    end
`else
    m_det[u] = valid;
    if (valid != 0) m_dir[u] = idx;
`endif
    m_best[u] = best;
    m_sel[u]  = nsel;
  endfunction

  // Drive whole lines until every strip has received its quota of tracked-class hits.
  task automatic drive_lines(input int u, input int q[NZ]);
    int rem[NZ];
    int left, lines, z;
    logic hit, noise;
    rem = q;
    lines = 0;
    left = 1;
    while (left != 0 && lines < 20) begin
      for (int c = 0; c < H; c++) begin
        @(negedge clk);
        z = c / ZPX;
        if (z > NZ - 1) z = NZ - 1;
        hit = (rem[z] > 0) && ($urandom_range(0, 3) != 0);
        if (hit) rem[z]--;
        noise = 1'($urandom_range(0, 1));
        pv[u] = 1'b1;
        ch[u] = (m_sel[u] == 1) ? {hit, noise} : {noise, hit};
      end
      for (int g = 0; g < 4; g++) begin
        @(negedge clk);
        pv[u] = 1'b0;
        ch[u] = 2'b00;
      end
      lines++;
      left = 0;
      for (int k = 0; k < NZ; k++) left += rem[k];
    end
  endtask

  // Full frame plus vsync edge; reports frame_done latency (edges after E) and output snapshot.
  task automatic run_frame(input int u, input int q[NZ], input int nsel,
                           output int lat, output int pulses,
                           output int o_dir, output int o_det, output int o_best);
    sc[u] = 1'(nsel);
    drive_lines(u, q);
    @(negedge clk);
    vs[u] = 1'b0;
    @(posedge clk);
    lat = -1; pulses = 0; o_dir = -1; o_det = -1; o_best = -1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk);
      #1;
      if (fd[u]) begin
        pulses++;
        if (lat < 0) begin
          lat = k; o_dir = int'(dir[u]); o_det = int'(det[u]); o_best = best_of(u);
        end
      end
    end
    @(negedge clk);
    vs[u] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int q[NZ];
    int lat, pulses, o_dir, o_det, o_best;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      n_total++; if (dir[u] !== 3'd0) $display("FAIL reset_dir u%0d: got %0d expected 0", u, dir[u]); else n_pass++;
      n_total++; if (det[u] !== 1'b0) $display("FAIL reset_det u%0d: got %0d expected 0", u, det[u]); else n_pass++;
      n_total++; if (best_of(u) !== 0) $display("FAIL reset_best u%0d: got %0d expected 0", u, best_of(u)); else n_pass++;
      n_total++; if (fd[u] !== 1'b0) $display("FAIL reset_fd u%0d: got %0d expected 0", u, fd[u]); else n_pass++;
    end
    // Commit something, then reset in the middle of the next frame.
    q = '{0, 0, 300, 0, 0};
    run_frame(0, q, 0, lat, pulses, o_dir, o_det, o_best);
    model_frame(0, q, 0);
    n_total++; if (o_best !== m_best[0]) $display("FAIL pre_reset_best: got %0d expected %0d", o_best, m_best[0]); else n_pass++;
    drive_lines(0, q);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); pv[0] = 1'b1; ch[0] = 2'b11;
    end
    rst_n = 1'b0;
    @(negedge clk);
    pv[0] = 1'b0; ch[0] = 2'b00;
    #1;
    n_total++; if (dir[0] !== 3'd0) $display("FAIL midreset_dir: got %0d expected 0", dir[0]); else n_pass++;
    n_total++; if (det[0] !== 1'b0) $display("FAIL midreset_det: got %0d expected 0", det[0]); else n_pass++;
    n_total++; if (bc0 !== 17'd0) $display("FAIL midreset_best: got %0d expected 0", bc0); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    q = '{0, 0, 0, 0, 0};
    run_frame(0, q, 0, lat, pulses, o_dir, o_det, o_best);
    model_frame(0, q, 0);
    n_total++; if (lat !== LAT) $display("FAIL postreset_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (pulses !== 1) $display("FAIL postreset_pulses: got %0d expected 1", pulses); else n_pass++;
    n_total++; if (o_det !== m_det[0]) $display("FAIL postreset_det: got %0d expected %0d", o_det, m_det[0]); else n_pass++;
    n_total++; if (o_best !== m_best[0]) $display("FAIL postreset_best: got %0d expected %0d", o_best, m_best[0]); else n_pass++;
  endtask

  task automatic test_patterns();
    int tbl[3][NZ];
    int q[NZ];
    int lat, pulses, o_dir, o_det, o_best;
    tbl = '{'{0, 0, 500, 0, 0}, '{0, 250, 0, 250, 0}, '{0, 0, 0, 0, 199}};
    for (int t = 0; t < 3; t++) begin
      q = tbl[t];
      run_frame(0, q, 0, lat, pulses, o_dir, o_det, o_best);
      model_frame(0, q, 0);
      n_total++; if (lat !== LAT) $display("FAIL pattern%0d_latency: got %0d expected %0d", t, lat, LAT); else n_pass++;
      n_total++; if (pulses !== 1) $display("FAIL pattern%0d_pulses: got %0d expected 1", t, pulses); else n_pass++;
      n_total++; if (o_dir !== m_dir[0]) $display("FAIL pattern%0d_dir: got %0d expected %0d", t, o_dir, m_dir[0]); else n_pass++;
      n_total++; if (o_det !== m_det[0]) $display("FAIL pattern%0d_det: got %0d expected %0d", t, o_det, m_det[0]); else n_pass++;
      n_total++; if (o_best !== m_best[0]) $display("FAIL pattern%0d_best: got %0d expected %0d", t, o_best, m_best[0]); else n_pass++;
    end
  endtask

  task automatic test_persist();
    int q[NZ];
    int lat, pulses, o_dir, o_det, o_best;
    for (int f = 0; f < 6; f++) begin
      q = (f < 3) ? '{250, 0, 0, 0, 0} : '{0, 0, 0, 0, 250};
      run_frame(0, q, 0, lat, pulses, o_dir, o_det, o_best);
      model_frame(0, q, 0);
      n_total++; if (lat !== LAT) $display("FAIL persist%0d_latency: got %0d expected %0d", f, lat, LAT); else n_pass++;
      n_total++; if (o_dir !== m_dir[0]) $display("FAIL persist%0d_dir: got %0d expected %0d", f, o_dir, m_dir[0]); else n_pass++;
      n_total++; if (o_det !== m_det[0]) $display("FAIL persist%0d_det: got %0d expected %0d", f, o_det, m_det[0]); else n_pass++;
      n_total++; if (o_best !== m_best[0]) $display("FAIL persist%0d_best: got %0d expected %0d", f, o_best, m_best[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int q[NZ];
    int nsel, lat, pulses, o_dir, o_det, o_best;
    for (int f = 0; f < 6; f++) begin
      for (int z = 0; z < NZ; z++) q[z] = int'($urandom_range(0, 250));
      nsel = int'($urandom_range(0, 1));
      run_frame(0, q, nsel, lat, pulses, o_dir, o_det, o_best);
      model_frame(0, q, nsel);
      n_total++; if (lat !== LAT) $display("FAIL random%0d_latency: got %0d expected %0d", f, lat, LAT); else n_pass++;
      n_total++; if (pulses !== 1) $display("FAIL random%0d_pulses: got %0d expected 1", f, pulses); else n_pass++;
      n_total++; if (o_dir !== m_dir[0]) $display("FAIL random%0d_dir: got %0d expected %0d", f, o_dir, m_dir[0]); else n_pass++;
      n_total++; if (o_det !== m_det[0]) $display("FAIL random%0d_det: got %0d expected %0d", f, o_det, m_det[0]); else n_pass++;
      n_total++; if (o_best !== m_best[0]) $display("FAIL random%0d_best: got %0d expected %0d", f, o_best, m_best[0]); else n_pass++;
    end
  endtask

  // Narrow-counter unit: class 1 selected one frame ahead, class 0 hits act as noise.
  task automatic test_saturation();
    int q[NZ];
    int lat, pulses, o_dir, o_det, o_best;
    for (int f = 0; f < 2; f++) begin
      q = (f == 0) ? '{0, 0, 0, 0, 0} : '{40, 0, 0, 0, 0};
      run_frame(1, q, 1, lat, pulses, o_dir, o_det, o_best);
      model_frame(1, q, 1);
      n_total++; if (lat !== LAT) $display("FAIL sat%0d_latency: got %0d expected %0d", f, lat, LAT); else n_pass++;
      n_total++; if (o_dir !== m_dir[1]) $display("FAIL sat%0d_dir: got %0d expected %0d", f, o_dir, m_dir[1]); else n_pass++;
      n_total++; if (o_det !== m_det[1]) $display("FAIL sat%0d_det: got %0d expected %0d", f, o_det, m_det[1]); else n_pass++;
      n_total++; if (o_best !== m_best[1]) $display("FAIL sat%0d_best: got %0d expected %0d", f, o_best, m_best[1]); else n_pass++;
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      pv[u] = 1'b0; vs[u] = 1'b1; ch[u] = 2'b00; sc[u] = 1'b0;
    end
    model_reset();
    test_reset();
    test_patterns();
    test_persist();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
